// File: rtl/boron_addkey_sbox_stage.sv
// Boron round stage: round-key XOR followed by 16 parallel 4-bit S-boxes,
// registered onto a valid/ready stream with an optional 2-entry skid buffer.

module boron_sbox4 (
   input  logic [3:0] x,
   output logic [3:0] y
);
   always_comb begin
      y = 4'h0;
      case (x)
         4'h0: y = 4'hE;
         4'h1: y = 4'h4;
         4'h2: y = 4'hB;
         4'h3: y = 4'h1;
         4'h4: y = 4'h7;
         4'h5: y = 4'h9;
         4'h6: y = 4'hC;
         4'h7: y = 4'hA;
         4'h8: y = 4'hD;
         4'h9: y = 4'h2;
         4'hA: y = 4'h0;
         4'hB: y = 4'hF;
         4'hC: y = 4'h8;
         4'hD: y = 4'h5;
         4'hE: y = 4'h3;
         default: y = 4'h6;
      endcase
   end
endmodule

module boron_addkey_sbox_stage #(
   parameter int SKID    = 1,
   parameter int ROUND_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [63:0]        in_state,
   input  logic [63:0]        in_rkey,
   input  logic [ROUND_W-1:0] in_round,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [63:0]        out_state,
   output logic [ROUND_W-1:0] out_round,
   output logic [15:0]        beat_count
);
   logic [63:0]        mixed;
   logic [63:0]        subbed;
   logic               accept;
   logic               xfer;
   logic               valid_r;
   logic               ready_r;
   logic [63:0]        data_r;
   logic [ROUND_W-1:0] round_r;
   logic [15:0]        count_r;

   assign mixed = in_state ^ in_rkey;

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      boron_sbox4 u_sbox (.x(mixed[4*i +: 4]), .y(subbed[4*i +: 4]));
   end

   assign accept     = in_valid & in_ready;
   assign xfer       = valid_r & out_ready;
   assign in_ready   = ready_r;
   assign out_valid  = valid_r;
   assign out_state  = data_r;
   assign out_round  = round_r;
   assign beat_count = count_r;

   always_ff @(posedge clk) begin
      if (rst) count_r <= 16'h0000;
      else if (xfer) count_r <= count_r + 16'h0001;
   end

   if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
      skid_state_t        state, state_nxt;
      logic [63:0]        skid_data;
      logic [ROUND_W-1:0] skid_round;

      always_comb begin
         state_nxt = state;
         case (state)
            EMPTY:   if (accept) state_nxt = ONE;
            ONE: begin
               if (accept && !xfer) state_nxt = TWO;
               else if (!accept && xfer) state_nxt = EMPTY;
            end
            TWO:     if (xfer) state_nxt = ONE;
            default: state_nxt = EMPTY;
         endcase
      end

      // in_ready is taken from the next state so it never depends on out_ready combinationally
      always_ff @(posedge clk) begin
         if (rst) begin
            state   <= EMPTY;
            ready_r <= 1'b0;
         end else begin
            state   <= state_nxt;
            ready_r <= (state_nxt != TWO);
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            data_r     <= '0;
            round_r    <= '0;
            skid_data  <= '0;
            skid_round <= '0;
         end else begin
            case (state)
               EMPTY: if (accept) begin
                  data_r  <= subbed;
                  round_r <= in_round;
               end
               ONE: if (accept) begin
                  if (xfer) begin
                     data_r  <= subbed;
                     round_r <= in_round;
                  end else begin
                     skid_data  <= subbed;
                     skid_round <= in_round;
                  end
               end
               TWO: if (xfer) begin
                  data_r  <= skid_data;
                  round_r <= skid_round;
               end
               default: ;
            endcase
         end
      end

      assign valid_r = (state != EMPTY);
   end else begin : g_single
      logic valid_q;
      logic live;

      // live holds in_ready low through the reset cycle and the edge that releases it
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            live    <= 1'b0;
            data_r  <= '0;
            round_r <= '0;
         end else begin
            live <= 1'b1;
            if (accept) begin
               valid_q <= 1'b1;
               data_r  <= subbed;
               round_r <= in_round;
            end else if (xfer) begin
               valid_q <= 1'b0;
            end
         end
      end

      assign valid_r = valid_q;
      assign ready_r = live & (~valid_q | out_ready);
   end
endmodule

// File: tb/tb_boron_addkey_sbox_stage.sv
// Directed bench for boron_addkey_sbox_stage with a queue-based reference
// model checked on every cycle, plus literal S-box expectations.

module tb_boron_addkey_sbox_stage;
   localparam int ROUND_W = 5;
   // Nibble k holds SBOX[k]
   localparam logic [63:0] SBOX_TBL = 64'h6358F02DAC971B4E;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [63:0]        in_state = '0;
   logic [63:0]        in_rkey = '0;
   logic [ROUND_W-1:0] in_round = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [63:0]        out_state;
   logic [ROUND_W-1:0] out_round;
   logic [15:0]        beat_count;

   int n_vec = 0;
   int n_err = 0;

   boron_addkey_sbox_stage #(.SKID(1), .ROUND_W(ROUND_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .in_rkey(in_rkey), .in_round(in_round),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_state(out_state), .out_round(out_round),
      .beat_count(beat_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sbox64(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int n = 0; n < 16; n++)
         y = y | ({60'd0, SBOX_TBL[4*((x >> (4*n)) & 64'hF) +: 4]} << (4*n));
      return y;
   endfunction

   // Reference: FIFO of expected beats, capacity 2, output visible one edge after accept
   logic [63:0]        mq_s[$];
   logic [ROUND_W-1:0] mq_r[$];
   logic [15:0]        m_cnt = '0;
   bit                 m_rdy = 0;
   bit                 armed = 0;

   always @(negedge clk) begin
      bit m_xfer, m_acc;
      if (armed) begin
         chk("out_valid", {63'd0, out_valid}, {63'd0, mq_s.size() != 0});
         if (mq_s.size() != 0) begin
            chk("out_state", out_state, mq_s[0]);
            chk("out_round", {59'd0, out_round}, {59'd0, mq_r[0]});
         end
         chk("beat_count", {48'd0, beat_count}, {48'd0, m_cnt});
         chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
      end
      if (rst) begin
         mq_s.delete();
         mq_r.delete();
         m_cnt = '0;
         m_rdy = 0;
         armed = 1;
      end else if (armed) begin
         m_xfer = (mq_s.size() != 0) && out_ready;
         m_acc  = in_valid && m_rdy;
         if (m_xfer) begin
            void'(mq_s.pop_front());
            void'(mq_r.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         if (m_acc) begin
            mq_s.push_back(sbox64(in_state ^ in_rkey));
            mq_r.push_back(in_round);
         end
         m_rdy = mq_s.size() < 2;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat; returns 1 time unit after the accepting edge
   task automatic put(input logic [63:0] s, input logic [63:0] k, input logic [ROUND_W-1:0] r);
      int waited;
      waited = 0;
      in_valid = 1'b1;
      in_state = s;
      in_rkey  = k;
      in_round = r;
      while (!in_ready && waited < 50) begin
         cyc();
         waited++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL put_timeout: in_ready stuck low at %0t", $time);
      end
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) cyc();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_state", out_state, 64'd0);
      chk("rst_out_round", {59'd0, out_round}, 64'd0);
      chk("rst_beat_count", {48'd0, beat_count}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      rst = 1'b0;
      cyc();
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Single beat
      put(64'd0, 64'd0, 5'd3);
      chk("single_valid", {63'd0, out_valid}, 64'd1);
      chk("single_state", out_state, 64'hEEEEEEEEEEEEEEEE);
      chk("single_round", {59'd0, out_round}, 64'd3);
      out_ready = 1'b1;
      cyc();

      // S-box ordering through state and through key
      put(64'h0123456789ABCDEF, 64'd0, 5'd1);
      chk("sbox_state", out_state, 64'hE4B179CAD20F8536);
      cyc();
      put(64'd0, 64'h0123456789ABCDEF, 5'd2);
      chk("sbox_key", out_state, 64'hE4B179CAD20F8536);
      cyc();

      // Streaming 32 back-to-back beats
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         in_state = 64'h0F1E2D3C4B5A6978 * (i + 1);
         in_rkey  = {32'(i), 32'hA5A5A5A5};
         in_round = ROUND_W'(i);
         chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      chk("stream_count", {48'd0, beat_count}, 64'd32);

      // Backpressure into the skid buffer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_state  = 64'd0;                in_rkey = '0; in_round = 5'd10;
      cyc();
      chk("bp_rdy_a", {63'd0, in_ready}, 64'd1);
      chk("bp_out_a", out_state, 64'hEEEEEEEEEEEEEEEE);
      in_state  = 64'h1111111111111111; in_round = 5'd11;
      cyc();
      chk("bp_rdy_b", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_1", out_state, 64'hEEEEEEEEEEEEEEEE);
      in_state  = 64'h2222222222222222; in_round = 5'd12;
      cyc();
      chk("bp_rdy_c", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_2", out_state, 64'hEEEEEEEEEEEEEEEE);
      out_ready = 1'b1;
      cyc();
      chk("bp_out_b", out_state, 64'h4444444444444444);
      chk("bp_rdy_after", {63'd0, in_ready}, 64'd1);
      cyc();
      in_valid = 1'b0;
      chk("bp_out_c", out_state, 64'hBBBBBBBBBBBBBBBB);
      chk("bp_round_c", {59'd0, out_round}, 64'd12);
      cyc();
      chk("bp_drained", {63'd0, out_valid}, 64'd0);

      // Reset while two beats are held
      out_ready = 1'b0;
      put(64'h3333333333333333, 64'd0, 5'd20);
      put(64'h4444444444444444, 64'd0, 5'd21);
      chk("mid_full", {63'd0, in_ready}, 64'd0);
      rst = 1'b1;
      cyc();
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_count", {48'd0, beat_count}, 64'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      cyc();
      put(64'd0, 64'hFFFFFFFFFFFFFFFF, 5'd7);
      chk("mid_after", out_state, 64'h6666666666666666);
      cyc();

      // Counter wrap
      do_reset();
      in_valid = 1'b1;
      in_state = 64'hDEADBEEFCAFEF00D;
      in_rkey  = 64'h0123456789ABCDEF;
      repeat (65535) cyc();
      in_valid = 1'b0;
      cyc();
      chk("wrap_ffff", {48'd0, beat_count}, 64'h000000000000FFFF);
      put(64'd5, 64'd0, 5'd1);
      cyc();
      chk("wrap_zero", {48'd0, beat_count}, 64'd0);

      repeat (2) cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/boron_addkey_sbox_stage.md
Name: boron_addkey_sbox_stage

Overview:
- Registered round stage for the Boron encryption datapath. It sits directly upstream of the 64-bit permutation block shuffle.
- Each accepted beat XORs the 64-bit state with a 64-bit round key. The result then passes through 16 parallel 4-bit Boron S-boxes.
- The output is presented on a valid/ready stream, which the permutation layer consumes.
- An optional 2-entry skid buffer keeps in_ready registered, so long round pipelines close timing.

Parameters:
- SKID, default 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with in_ready = ~out_valid | out_ready.
- ROUND_W, default 5: width of the round tag carried alongside the data (25 rounds fit in 5 bits).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_state  in  64  cipher state before key addition.
- in_rkey  in  64  round key for this beat.
- in_round  in  ROUND_W  round tag, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream (block shuffle stage) accepts.
- out_state  out  64  S(in_state ^ in_rkey), nibble-wise.
- out_round  out  ROUND_W  tag of the presented beat.
- beat_count  out  16  number of completed output transfers; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset is synchronous and active-high.
  - While rst = 1 at a clock edge: out_valid = 0, out_state = 0, out_round = 0, beat_count = 0, and the skid buffer is emptied.
  - in_ready = 0 during the reset cycle and rises the cycle after rst deasserts.
  - A reset asserted mid-operation discards all held beats; no partial beat is emitted.
- Datapath, per beat:
  - x = in_state ^ in_rkey.
  - For nibble i (bits [4i+3:4i], i = 0..15): out nibble i = SBOX[x nibble i].
  - SBOX, input 0..F -> output: E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6.
  - Purely bitwise; no carries, no width growth.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Data and tag must stay stable while out_valid = 1 and out_ready = 0.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge N is presented on out_* from edge N.
  - Sustained throughput is 1 beat per cycle with out_ready held high.
- SKID = 1 states:
  - EMPTY: out_valid = 0, in_ready = 1.
    - On accept -> ONE.
  - ONE: out_valid = 1, in_ready = 1.
    - Accept without output transfer -> TWO (new beat goes to the skid register).
    - Output transfer without accept -> EMPTY.
    - Both simultaneously -> stay ONE, new beat replaces the output.
  - TWO: out_valid = 1, in_ready = 0.
    - On output transfer, the skid beat moves to output -> ONE.
  - in_ready is a registered function of state only, with no combinational path from out_ready.
- SKID = 0:
  - Single output register; in_ready = ~out_valid | out_ready (combinational).
  - Simultaneous output transfer and accept replaces the register contents in the same edge.
- Ordering: beats leave in acceptance order and are never duplicated or dropped.
- beat_count increments by 1 on each output transfer.
- in_valid = 1 while in_ready = 0 has no effect; the upstream stage must hold its beat.

Test Plan:
- Reset then single beat: in_state = 0, in_rkey = 0, in_round = 3 -> next cycle out_valid = 1, out_state = 0xEEEEEEEEEEEEEEEE, out_round = 3.
- S-box ordering: in_state = 0x0123456789ABCDEF, in_rkey = 0 -> out_state = 0xE4B179CAD20F8536. Repeat with in_state = 0, in_rkey = 0x0123456789ABCDEF -> same result.
- Streaming: 32 back-to-back beats with out_ready = 1 -> one output per cycle, in_ready never drops, beat_count = 32.
- Backpressure (SKID = 1): out_ready = 0 while 3 beats are offered -> 2 accepted, in_ready = 0 after the second, out_state held stable. Then out_ready = 1 -> both beats emitted in order, third beat accepted.
- Reset mid-operation: in state TWO, assert rst for one cycle -> out_valid = 0, beat_count = 0, nothing emitted. The next beat, in_state = 0 with in_rkey = 0xFFFFFFFFFFFFFFFF, gives out_state = 0x6666666666666666.
- Counter wrap: preload 65535 transfers (or force the count) -> the next transfer gives beat_count = 0x0000.
